if_id_fifo: RTL and testbench
=============================

IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
- REQ-001 SHALL have parameter DEPTH, default 4: number of entries; power of two, 2..8.
- REQ-002 SHALL have parameter TRAP_W, default `TRAP_LEN: width of the trap bus.
- REQ-003 SHALL have clk  input  1  clock; all state updates on rising edge.
- REQ-004 SHALL have rst_n  input  1  reset; asynchronous, active-low.
- REQ-005 SHALL have flush_i  input  1  discard all entries (redirect or trap).
- REQ-006 SHALL have in_valid_i  input  1  fetch stage presents an instruction.
- REQ-007 SHALL have in_ready_o  output  1  buffer accepts this cycle.
- REQ-008 SHALL have in_pc_i  input  32  instruction address.
- REQ-009 SHALL have in_inst_i  input  32  instruction word.
- REQ-010 SHALL have in_trap_i  input  TRAP_W  fetch trap bits (page fault, etc.).
- REQ-011 SHALL have in_rvc_i  input  1  compressed-instruction flag.
- REQ-012 SHALL have in_pdt_i  input  1  branch-predicted-taken flag.
- REQ-013 SHALL have out_valid_o  output  1  head entry valid to decode.
- REQ-014 SHALL have out_ready_i  input  1  decode consumes head.
- REQ-015 SHALL have out_pc_o, out_inst_o, out_trap_o, out_rvc_o, out_pdt_o  output  32/32/TRAP_W/1/1  head entry fields.
- REQ-016 SHALL have count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
- REQ-017 Storage SHALL be a circular buffer: write pointer, read pointer, and count, with pointers of width $clog2(DEPTH) wrapping modulo DEPTH.
- REQ-018 Enqueue SHALL occur iff in_valid_i && in_ready_o; dequeue iff out_valid_o && out_ready_i.
- REQ-019 in_ready_o SHALL equal (count_o != DEPTH) && !trap_hold && !flush_i; it SHALL NOT depend on out_ready_i, so a full buffer stalls for one cycle even when the head is being consumed.
- REQ-020 out_valid_o SHALL equal (count_o != 0) && !flush_i; out fields SHALL be driven combinationally from the head entry storage, and SHALL equal 0 when count_o == 0.
- REQ-021 Latency: an entry enqueued at edge N SHALL be visible on the out port in the cycle after edge N; there is no same-cycle bypass.
- REQ-022 Simultaneous enqueue and dequeue SHALL leave count_o unchanged and advance both pointers.
- REQ-023 An entry with in_trap_i != 0 SHALL be stored with its inst field replaced by 32'h00000013 (NOP), and with pc, trap, rvc and pdt stored unchanged.
- REQ-024 Enqueue of a trapping entry SHALL set sticky flag trap_hold, which blocks all further enqueues until flush.
- REQ-025 flush_i SHALL, at the next edge, zero count and both pointers and clear trap_hold, with priority over a simultaneous enqueue or dequeue (neither takes effect).
- REQ-026 Entry payload registers SHALL NOT require reset; only control state (pointers, count, trap_hold) is reset.
- REQ-027 Pointer wrap: after DEPTH enqueues and DEPTH dequeues, entries SHALL emerge in FIFO order with no loss or duplication.

Reset
- REQ-028 While rst_n is low, regardless of clk: count, pointers and trap_hold SHALL be 0, out_valid_o SHALL be 0, in_ready_o SHALL be 1 (when flush_i is 0), and count_o SHALL be 0.
- REQ-029 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); the first enqueue after rst_n rises SHALL appear at the head.

Verification
- REQ-030 Fill/drain: with out_ready_i=0, enqueue pc 0x80000000,+4,+8,+C -> count_o=4 and in_ready_o=0; then out_ready_i=1 -> pcs emerge in order, one per cycle, then out_valid_o=0.
- REQ-031 Streaming: in_valid_i=1 and out_ready_i=1 continuously, DEPTH=4, 20 entries -> count_o stays 1 after the first cycle, all 20 pcs are in order, and wrap is exercised.
- REQ-032 Trap: enqueue pc 0x80001000 with inst 0xDEADBEEF and trap bit `TRAP_INST_PAGE_FAULT set -> out_inst_o=0x00000013, trap bit set, in_ready_o=0 until flush_i pulses, then 1.
- REQ-033 Flush collision: with 3 entries held, assert flush_i together with in_valid_i and out_ready_i -> during that cycle out_valid_o=0 and in_ready_o=0; next cycle count_o=0 and nothing is enqueued.
- REQ-034 Async reset: with 2 entries held, drop rst_n between clock edges -> out_valid_o=0 and count_o=0 without a clock edge; after release, enqueue pc 0x30000000 -> that pc is at the head one cycle later.

Source files
------------

// File: rtl/if_id_fifo.sv
// Fetch-to-decode instruction buffer: circular FIFO with flush and sticky trap hold.
// A trapping fetch is stored as a NOP and blocks further enqueues until the next flush.

`ifndef TRAP_LEN
`define TRAP_LEN 4
`endif
`ifndef TRAP_INST_PAGE_FAULT
`define TRAP_INST_PAGE_FAULT 2
`endif

module if_id_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TRAP_W = `TRAP_LEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                in_pc_i,
  input  logic [31:0]                in_inst_i,
  input  logic [TRAP_W-1:0]          in_trap_i,
  input  logic                       in_rvc_i,
  input  logic                       in_pdt_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_pc_o,
  output logic [31:0]                out_inst_o,
  output logic [TRAP_W-1:0]          out_trap_o,
  output logic                       out_rvc_o,
  output logic                       out_pdt_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [31:0] NopInst = 32'h0000_0013;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          trap_hold_q, trap_hold_d;

  logic [31:0]       pc_mem   [DEPTH];
  logic [31:0]       inst_mem [DEPTH];
  logic [TRAP_W-1:0] trap_mem [DEPTH];
  logic              rvc_mem  [DEPTH];
  logic              pdt_mem  [DEPTH];

  logic enq, deq, empty, in_trap;

  assign empty   = (count_q == '0);
  assign in_trap = |in_trap_i;

  // Ready deliberately ignores out_ready_i to keep the fetch handshake off the decode path.
  assign in_ready_o  = (count_q != FullCnt) && !trap_hold_q && !flush_i;
  assign out_valid_o = !empty && !flush_i;
  assign enq         = in_valid_i && in_ready_o;
  assign deq         = out_valid_o && out_ready_i;
  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    trap_hold_d = trap_hold_q;
    if (flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      trap_hold_d = 1'b0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (in_trap) trap_hold_d = 1'b1;
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      trap_hold_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      trap_hold_q <= trap_hold_d;
    end
  end

  // Payload storage carries no reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= in_pc_i;
      inst_mem[wr_ptr_q] <= in_trap ? NopInst : in_inst_i;
      trap_mem[wr_ptr_q] <= in_trap_i;
      rvc_mem[wr_ptr_q]  <= in_rvc_i;
      pdt_mem[wr_ptr_q]  <= in_pdt_i;
    end
  end

  always_comb begin
    out_pc_o   = '0;
    out_inst_o = '0;
    out_trap_o = '0;
    out_rvc_o  = 1'b0;
    out_pdt_o  = 1'b0;
    if (!empty) begin
      out_pc_o   = pc_mem[rd_ptr_q];
      out_inst_o = inst_mem[rd_ptr_q];
      out_trap_o = trap_mem[rd_ptr_q];
      out_rvc_o  = rvc_mem[rd_ptr_q];
      out_pdt_o  = pdt_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo: vector table for fill/drain plus hand-written
// sequences for streaming, trap hold, flush collision and asynchronous reset.

`ifndef TRAP_LEN
`define TRAP_LEN 4
`endif
`ifndef TRAP_INST_PAGE_FAULT
`define TRAP_INST_PAGE_FAULT 2
`endif

module tb_if_id_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = `TRAP_LEN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_inst;
  logic [TW-1:0]     in_trap;
  logic              in_rvc;
  logic              in_pdt;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
  logic [TW-1:0]     out_trap;
  logic              out_rvc;
  logic              out_pdt;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_fifo #(.DEPTH(DEPTH), .TRAP_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pc_i     (in_pc),
    .in_inst_i   (in_inst),
    .in_trap_i   (in_trap),
    .in_rvc_i    (in_rvc),
    .in_pdt_i    (in_pdt),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_pc_o    (out_pc),
    .out_inst_o  (out_inst),
    .out_trap_o  (out_trap),
    .out_rvc_o   (out_rvc),
    .out_pdt_o   (out_pdt),
    .count_o     (count)
  );

  typedef struct {
    logic        flush;
    logic        inv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rvc;
    logic        pdt;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_rvc;
    logic        e_pdt;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_trap = '0;
    in_rvc = 1'b0; in_pdt = 1'b0; out_ready = 1'b0;
  endtask

  // Drive on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic [TW-1:0] trap, input logic ord);
    @(negedge clk);
    flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; in_trap = trap;
    in_rvc = 1'b0; in_pdt = 1'b0; out_ready = ord;
    #1;
  endtask

  function automatic vec_t mk(logic fl, logic iv, logic [31:0] pc, logic [31:0] inst,
                              logic rvc, logic pdt, logic ordy, logic e_rdy, logic e_ov,
                              logic [31:0] e_pc, logic [31:0] e_inst, logic e_rvc,
                              logic e_pdt, logic [2:0] e_cnt);
    vec_t v;
    v.flush = fl; v.inv = iv; v.pc = pc; v.inst = inst; v.rvc = rvc; v.pdt = pdt;
    v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_rvc = e_rvc; v.e_pdt = e_pdt; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    logic [TW-1:0] pf;
    pf = '0;
    pf[`TRAP_INST_PAGE_FAULT] = 1'b1;

    // Fill four entries with decode stalled, then drain in order.
    vecs[0]  = mk(0, 0, 32'h0,         32'h0,         0, 0, 0, 1, 0, 32'h0,         32'h0,         0, 0, 0);
    vecs[1]  = mk(0, 1, 32'h8000_0000, 32'h0000_0093, 0, 0, 0, 1, 0, 32'h0,         32'h0,         0, 0, 0);
    vecs[2]  = mk(0, 1, 32'h8000_0004, 32'h0010_0113, 1, 0, 0, 1, 1, 32'h8000_0000, 32'h0000_0093, 0, 0, 1);
    vecs[3]  = mk(0, 1, 32'h8000_0008, 32'h0020_0193, 0, 1, 0, 1, 1, 32'h8000_0000, 32'h0000_0093, 0, 0, 2);
    vecs[4]  = mk(0, 1, 32'h8000_000C, 32'h0030_0213, 0, 0, 0, 1, 1, 32'h8000_0000, 32'h0000_0093, 0, 0, 3);
    vecs[5]  = mk(0, 1, 32'h8000_0010, 32'h0040_0293, 0, 0, 0, 0, 1, 32'h8000_0000, 32'h0000_0093, 0, 0, 4);
    vecs[6]  = mk(0, 0, 32'h0,         32'h0,         0, 0, 1, 0, 1, 32'h8000_0000, 32'h0000_0093, 0, 0, 4);
    vecs[7]  = mk(0, 0, 32'h0,         32'h0,         0, 0, 1, 1, 1, 32'h8000_0004, 32'h0010_0113, 1, 0, 3);
    vecs[8]  = mk(0, 0, 32'h0,         32'h0,         0, 0, 1, 1, 1, 32'h8000_0008, 32'h0020_0193, 0, 1, 2);
    vecs[9]  = mk(0, 0, 32'h0,         32'h0,         0, 0, 1, 1, 1, 32'h8000_000C, 32'h0030_0213, 0, 0, 1);
    vecs[10] = mk(0, 0, 32'h0,         32'h0,         0, 0, 1, 1, 0, 32'h0,         32'h0,         0, 0, 0);

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    #12;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      flush = vecs[i].flush; in_valid = vecs[i].inv; in_pc = vecs[i].pc;
      in_inst = vecs[i].inst; in_trap = '0; in_rvc = vecs[i].rvc; in_pdt = vecs[i].pdt;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].e_pc);
      check($sformatf("vec%0d_out_inst", i), out_inst, vecs[i].e_inst);
      check($sformatf("vec%0d_out_rvc", i), 32'(out_rvc), 32'(vecs[i].e_rvc));
      check($sformatf("vec%0d_out_pdt", i), 32'(out_pdt), 32'(vecs[i].e_pdt));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
    end

    // Streaming 20 entries through with both sides always ready; pointers wrap 5 times.
    for (int k = 0; k <= 20; k++) begin
      drive(0, (k < 20), 32'h4000_0000 + 32'(4 * k), 32'h0000_0013, '0, 1);
      if (k > 0) begin
        check($sformatf("stream%0d_count", k), 32'(count), 32'd1);
        check($sformatf("stream%0d_pc", k), out_pc, 32'h4000_0000 + 32'(4 * (k - 1)));
      end
    end
    drive(0, 0, 32'h0, 32'h0, '0, 0);
    check("stream_drained", 32'(count), 32'd0);

    // Trapping fetch is stored as NOP and holds off further enqueues until flush.
    drive(0, 1, 32'h8000_1000, 32'hDEAD_BEEF, pf, 0);
    check("trap_accept_ready", 32'(in_ready), 32'd1);
    drive(0, 1, 32'h8000_1004, 32'h0000_0093, '0, 0);
    check("trap_out_pc", out_pc, 32'h8000_1000);
    check("trap_out_inst", out_inst, 32'h0000_0013);
    check("trap_bit", 32'(out_trap[`TRAP_INST_PAGE_FAULT]), 32'd1);
    check("trap_hold_ready", 32'(in_ready), 32'd0);
    check("trap_count", 32'(count), 32'd1);
    drive(0, 1, 32'h8000_1004, 32'h0000_0093, '0, 1);
    drive(0, 1, 32'h8000_1004, 32'h0000_0093, '0, 0);
    check("trap_drained_count", 32'(count), 32'd0);
    check("trap_drained_ready", 32'(in_ready), 32'd0);
    drive(1, 0, 32'h0, 32'h0, '0, 0);
    check("trap_flush_ready", 32'(in_ready), 32'd0);
    drive(0, 0, 32'h0, 32'h0, '0, 0);
    check("trap_post_flush_ready", 32'(in_ready), 32'd1);

    // Flush collides with enqueue and dequeue; neither may take effect.
    for (int k = 0; k < 3; k++) drive(0, 1, 32'h1000_0000 + 32'(4 * k), 32'h0, '0, 0);
    drive(1, 1, 32'h1000_00F0, 32'h0, '0, 1);
    check("flush_count_before", 32'(count), 32'd3);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    drive(0, 0, 32'h0, 32'h0, '0, 0);
    check("flush_count_after", 32'(count), 32'd0);
    check("flush_out_valid_after", 32'(out_valid), 32'd0);
    check("flush_out_pc_after", out_pc, 32'h0);

    // Asynchronous reset between edges with two entries held.
    drive(0, 1, 32'h2000_0000, 32'h0, '0, 0);
    drive(0, 1, 32'h2000_0004, 32'h0, '0, 0);
    drive(0, 0, 32'h0, 32'h0, '0, 0);
    check("areset_pre_count", 32'(count), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_count", 32'(count), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    drive(0, 1, 32'h3000_0000, 32'h0000_0013, '0, 0);
    drive(0, 0, 32'h0, 32'h0, '0, 0);
    check("areset_head_pc", out_pc, 32'h3000_0000);
    check("areset_head_count", 32'(count), 32'd1);
    check("areset_head_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
